// File: rtl/stdp_pkg.sv
// Shared constants and arithmetic helpers for the STDP learning engine.
// Combinational helpers only: no latency and no flow control.
package stdp_pkg;

    localparam int DEF_NUM_PRE = 4;
    localparam int DEF_T_W     = 4;
    localparam int DEF_W_W     = 4;
    localparam int DEF_WIN     = 8;
    localparam int DEF_SHIFT   = 1;
    localparam int DEF_W_INIT  = 8;

    // Step size for a qualifying pairing; never below 1 so a clamped-to-zero
    // magnitude still nudges the weight.
    function automatic logic [31:0] stdp_delta(input logic [31:0] dt,
                                               input logic [31:0] win,
                                               input int          shift);
        logic [31:0] d;
        d = (win > dt) ? ((win - dt) >> shift) : 32'd0;
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [31:0] s;
        logic [31:0] lim;
        s   = a + b;
        lim = (32'd1 << w) - 32'd1;
        return (s > lim) ? lim : s;
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/stdp_spike_timer.sv
// Saturating time-since-spike counter plus per-channel armed flags; 1-cycle update.
// No backpressure: the spike strobe is sampled every cycle and a clear beats a set.
module stdp_spike_timer
    import stdp_pkg::*;
#(
    parameter int T_W   = DEF_T_W,
    parameter int N_ARM = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike,
    input  logic [N_ARM-1:0] clr,
    output logic [T_W-1:0]   t,
    output logic [N_ARM-1:0] armed
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t     <= '1;
            armed <= '0;
        end else begin
            if (spike) begin
                t <= '0;
            end else if (t != '1) begin
                t <= t + T_W'(1);
            end
            armed <= (armed | {N_ARM{spike}}) & ~clr;
        end
    end

endmodule

// File: rtl/stdp_array.sv
// STDP weight engine: NUM_PRE presynaptic channels into one postsynaptic neuron.
// Weights, flag and time_diff update one cycle after the spike; no backpressure.
module stdp_array
    import stdp_pkg::*;
#(
    parameter int NUM_PRE = DEF_NUM_PRE,
    parameter int T_W     = DEF_T_W,
    parameter int W_W     = DEF_W_W,
    parameter int WIN     = DEF_WIN,
    parameter int SHIFT   = DEF_SHIFT,
    parameter int W_INIT  = DEF_W_INIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PRE-1:0]     pre_spike,
    input  logic                   post_spike,
    input  logic                   learn_en,
    output logic [NUM_PRE*W_W-1:0] weight,
    output logic                   update_w_flag,
    output logic [T_W-1:0]         time_diff
);

    localparam logic [31:0] WIN_U = WIN;

    logic [NUM_PRE-1:0][T_W-1:0] pre_t;
    logic [NUM_PRE-1:0][T_W-1:0] dpre;
    logic [T_W-1:0]              post_t;
    logic [NUM_PRE-1:0]          pre_armed;
    logic [NUM_PRE-1:0]          post_armed;
    logic [NUM_PRE-1:0]          ltp;
    logic [NUM_PRE-1:0]          ltd;
    logic [NUM_PRE-1:0][W_W-1:0] w_q;
    logic [NUM_PRE-1:0][W_W-1:0] w_d;
    logic                        any_evt;
    logic [T_W-1:0]              td_d;

    for (genvar g = 0; g < NUM_PRE; g++) begin : g_pre
        stdp_spike_timer #(.T_W(T_W), .N_ARM(1)) u_tmr (
            .clk   (clk),
            .rst_n (rst_n),
            .spike (pre_spike[g]),
            .clr   (ltp[g]),
            .t     (pre_t[g]),
            .armed (pre_armed[g])
        );
    end

    // The post timer carries one armed bit per channel so each channel
    // consumes the postsynaptic spike independently.
    stdp_spike_timer #(.T_W(T_W), .N_ARM(NUM_PRE)) u_post (
        .clk   (clk),
        .rst_n (rst_n),
        .spike (post_spike),
        .clr   (ltd),
        .t     (post_t),
        .armed (post_armed)
    );

    always_comb begin
        dpre    = '0;
        ltp     = '0;
        ltd     = '0;
        w_d     = w_q;
        any_evt = 1'b0;
        td_d    = time_diff;
        for (int i = 0; i < NUM_PRE; i++) begin
            dpre[i] = pre_spike[i] ? '0 : pre_t[i];
            // A coincident pre spike counts as LTP at dt=0 and never as LTD.
            ltp[i]  = learn_en && post_spike && (pre_armed[i] || pre_spike[i])
                      && (32'(dpre[i]) < WIN_U);
            ltd[i]  = learn_en && pre_spike[i] && !post_spike && post_armed[i]
                      && (32'(post_t) < WIN_U);
            if (ltp[i]) begin
                w_d[i] = W_W'(sat_add(32'(w_q[i]),
                                      stdp_delta(32'(dpre[i]), WIN_U, SHIFT), W_W));
            end else if (ltd[i]) begin
                w_d[i] = W_W'(sat_sub(32'(w_q[i]),
                                      stdp_delta(32'(post_t), WIN_U, SHIFT)));
            end
            if ((ltp[i] || ltd[i]) && !any_evt) begin
                td_d    = ltp[i] ? dpre[i] : post_t;
                any_evt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_q           <= {NUM_PRE{W_W'(W_INIT)}};
            update_w_flag <= 1'b0;
            time_diff     <= '0;
        end else begin
            w_q           <= w_d;
            update_w_flag <= any_evt;
            time_diff     <= td_d;
        end
    end

    assign weight = w_q;

endmodule

// File: tb/tb_stdp_array.sv
// Scenario bench for stdp_array with a spec-level reference model feeding a scoreboard.
module tb_stdp_array;

    localparam int NP  = 4;
    localparam int TW  = 4;
    localparam int WW  = 4;
    localparam int WIN = 8;
    localparam int SH  = 1;
    localparam int WI  = 8;
    localparam int WMAX = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   pre_spike = '0;
    logic            post_spike = 1'b0;
    logic            learn_en = 1'b0;
    logic [NP*WW-1:0] weight;
    logic            update_w_flag;
    logic [TW-1:0]   time_diff;

    always #5 clk = ~clk;

    stdp_array #(
        .NUM_PRE(NP), .T_W(TW), .W_W(WW), .WIN(WIN), .SHIFT(SH), .W_INIT(WI)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pre_spike     (pre_spike),
        .post_spike    (post_spike),
        .learn_en      (learn_en),
        .weight        (weight),
        .update_w_flag (update_w_flag),
        .time_diff     (time_diff)
    );

    typedef struct packed {
        logic [NP*WW-1:0] w;
        logic             f;
        logic [TW-1:0]    td;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int m_pre_t[NP];
    int m_post_t;
    bit m_pre_arm[NP];
    bit m_post_arm[NP];
    int m_w[NP];
    int m_td;

    function automatic int ref_delta(input int dt);
        int d;
        d = (WIN - dt) >> SH;
        return (d < 1) ? 1 : d;
    endfunction

    function automatic exp_t snapshot(input bit f);
        exp_t e;
        for (int i = 0; i < NP; i++) e.w[i*WW +: WW] = m_w[i][WW-1:0];
        e.f  = f;
        e.td = m_td[TW-1:0];
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_pre_t[i] = WMAX; m_pre_arm[i] = 0; m_post_arm[i] = 0; m_w[i] = WI;
        end
        m_post_t = WMAX;
        m_td     = 0;
        sb.push_back(snapshot(1'b0));
    endtask

    task automatic model_edge(input logic [NP-1:0] pre, input logic post, input logic le);
        bit any;
        bit ltp[NP];
        bit ltd[NP];
        int dp;
        int t;
        any = 0;
        for (int i = 0; i < NP; i++) begin
            dp = pre[i] ? 0 : m_pre_t[i];
            ltp[i] = le && post && (m_pre_arm[i] || pre[i]) && (dp < WIN);
            ltd[i] = le && pre[i] && !post && m_post_arm[i] && (m_post_t < WIN);
            if (ltp[i]) begin
                t = m_w[i] + ref_delta(dp);
                m_w[i] = (t > WMAX) ? WMAX : t;
                if (!any) m_td = dp;
                any = 1;
            end else if (ltd[i]) begin
                t = m_w[i] - ref_delta(m_post_t);
                m_w[i] = (t < 0) ? 0 : t;
                if (!any) m_td = m_post_t;
                any = 1;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (ltp[i]) m_pre_arm[i] = 0;
            else if (pre[i]) m_pre_arm[i] = 1;
            if (ltd[i]) m_post_arm[i] = 0;
            else if (post) m_post_arm[i] = 1;
            if (pre[i]) m_pre_t[i] = 0;
            else if (m_pre_t[i] < WMAX) m_pre_t[i]++;
        end
        if (post) m_post_t = 0;
        else if (m_post_t < WMAX) m_post_t++;
        sb.push_back(snapshot(any));
    endtask

    task automatic settle_and_score(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            $display("FAIL %s sb_empty got=0 expected=1 entry", tag);
            errors++;
        end else begin
            e = sb.pop_front();
            if (weight !== e.w || update_w_flag !== e.f || time_diff !== e.td) begin
                $display("FAIL %s sb weight=%h flag=%b td=%0d expected weight=%h flag=%b td=%0d",
                         tag, weight, update_w_flag, time_diff, e.w, e.f, e.td);
                errors++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; pre_spike = '0; post_spike = 1'b0; learn_en = 1'b1;
        model_reset();
        settle_and_score("reset");
    endtask

    task automatic step(input logic [NP-1:0] pre, input logic post, input logic le);
        @(negedge clk);
        rst_n = 1'b1; pre_spike = pre; post_spike = post; learn_en = le;
        model_edge(pre, post, le);
        settle_and_score("step");
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (weight !== 16'h8888 || update_w_flag !== 1'b0 || time_diff !== 4'd0) begin
            $display("FAIL reset_state weight=%h flag=%b td=%0d expected 8888 0 0", weight, update_w_flag, time_diff);
            errors++;
        end
        step('0, 1'b1, 1'b1);
        checks++;
        if (weight !== 16'h8888 || update_w_flag !== 1'b0) begin
            $display("FAIL post_alone weight=%h flag=%b expected 8888 0", weight, update_w_flag);
            errors++;
        end
    endtask

    task automatic test_ltp();
        do_reset();
        step(4'b0001, 1'b0, 1'b1);
        idle(2);
        step('0, 1'b1, 1'b1);
        checks++;
        if (weight !== 16'h888B || update_w_flag !== 1'b1 || time_diff !== 4'd2) begin
            $display("FAIL ltp_dt2 weight=%h flag=%b td=%0d expected 888b 1 2", weight, update_w_flag, time_diff);
            errors++;
        end
        step('0, 1'b1, 1'b1);
        checks++;
        if (weight !== 16'h888B || update_w_flag !== 1'b0) begin
            $display("FAIL ltp_disarmed weight=%h flag=%b expected 888b 0", weight, update_w_flag);
            errors++;
        end
    endtask

    task automatic test_ltd();
        do_reset();
        step('0, 1'b1, 1'b1);
        step(4'b0010, 1'b0, 1'b1);
        checks++;
        if (weight !== 16'h8848 || update_w_flag !== 1'b1 || time_diff !== 4'd0) begin
            $display("FAIL ltd_dt0 weight=%h flag=%b td=%0d expected 8848 1 0", weight, update_w_flag, time_diff);
            errors++;
        end
        step(4'b0010, 1'b0, 1'b1);
        checks++;
        if (weight !== 16'h8848 || update_w_flag !== 1'b0) begin
            $display("FAIL ltd_repeat weight=%h flag=%b expected 8848 0", weight, update_w_flag);
            errors++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] up_exp[3];
        logic [15:0] dn_exp[3];
        up_exp[0] = 16'h8C88; up_exp[1] = 16'h8F88; up_exp[2] = 16'h8F88;
        dn_exp[0] = 16'h4888; dn_exp[1] = 16'h0888; dn_exp[2] = 16'h0888;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(4'b0100, 1'b1, 1'b1);
            checks++;
            if (weight !== up_exp[k] || update_w_flag !== 1'b1) begin
                $display("FAIL sat_up_%0d weight=%h flag=%b expected %h 1", k, weight, update_w_flag, up_exp[k]);
                errors++;
            end
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step('0, 1'b1, 1'b1);
            step(4'b1000, 1'b0, 1'b1);
            checks++;
            if (weight !== dn_exp[k] || update_w_flag !== 1'b1) begin
                $display("FAIL sat_dn_%0d weight=%h flag=%b expected %h 1", k, weight, update_w_flag, dn_exp[k]);
                errors++;
            end
            idle(10);
        end
    endtask

    task automatic test_window();
        do_reset();
        step(4'b0001, 1'b0, 1'b1);
        idle(9);
        step('0, 1'b1, 1'b1);
        checks++;
        if (weight !== 16'h8888 || update_w_flag !== 1'b0) begin
            $display("FAIL out_of_window weight=%h flag=%b expected 8888 0", weight, update_w_flag);
            errors++;
        end
        idle(40);
        checks++;
        if (dut.post_t !== 4'd15) begin
            $display("FAIL post_timer_sat got=%0d expected=15", dut.post_t);
            errors++;
        end
        for (int i = 0; i < NP; i++) begin
            checks++;
            if (dut.pre_t[i] !== 4'd15) begin
                $display("FAIL pre_timer_sat_%0d got=%0d expected=15", i, dut.pre_t[i]);
                errors++;
            end
        end
        step('0, 1'b1, 1'b1);
        checks++;
        if (weight !== 16'h8888 || update_w_flag !== 1'b0) begin
            $display("FAIL stale_post weight=%h flag=%b expected 8888 0", weight, update_w_flag);
            errors++;
        end
    endtask

    task automatic test_learn_disable_and_reset();
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        step('0, 1'b1, 1'b0);
        checks++;
        if (weight !== 16'h8888 || update_w_flag !== 1'b0) begin
            $display("FAIL frozen weight=%h flag=%b expected 8888 0", weight, update_w_flag);
            errors++;
        end
        // pre_armed[0] survived the frozen post, so this post pairs at dt=1.
        step('0, 1'b1, 1'b1);
        checks++;
        if (weight !== 16'h888B || update_w_flag !== 1'b1 || time_diff !== 4'd1) begin
            $display("FAIL unconsumed_arm weight=%h flag=%b td=%0d expected 888b 1 1", weight, update_w_flag, time_diff);
            errors++;
        end
        step(4'b0100, 1'b0, 1'b1);
        do_reset();
        checks++;
        if (weight !== 16'h8888 || update_w_flag !== 1'b0 || time_diff !== 4'd0) begin
            $display("FAIL mid_reset weight=%h flag=%b td=%0d expected 8888 0 0", weight, update_w_flag, time_diff);
            errors++;
        end
        step('0, 1'b1, 1'b1);
        checks++;
        if (weight !== 16'h8888 || update_w_flag !== 1'b0) begin
            $display("FAIL history_cleared weight=%h flag=%b expected 8888 0", weight, update_w_flag);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_ltp();
        test_ltd();
        test_saturation();
        test_window();
        test_learn_disable_and_reset();
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL sb_leftover got=%0d expected=0", sb.size());
            errors++;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stdp_array.md
Name: stdp_array

Overview:
Parametrised STDP learning engine for NUM_PRE presynaptic channels feeding one postsynaptic neuron.
- Tracks time since the last spike on every channel with saturating timers.
- Applies windowed, time-weighted potentiation (LTP, pre-before-post) and depression (LTD, post-before-pre) with saturating weight arithmetic and nearest-neighbour pairing.
- Sits between spike generators and the synapse-weight consumer; the packed weight bus drives downstream synaptic integration.

Parameters:
- NUM_PRE, 4, number of presynaptic channels (≥1)
- T_W, 4, spike-timer width in bits
- W_W, 4, per-channel weight width in bits
- WIN, 8, pairing window in cycles; a pairing qualifies iff dt < WIN; legal range 1..2^T_W-1
- SHIFT, 1, right-shift applied to the raw LTP/LTD magnitude
- W_INIT, 8, weight reset value (< 2^W_W)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pre_spike  in  NUM_PRE  presynaptic spike strobes, bit i = channel i
- post_spike  in  1  postsynaptic spike strobe
- learn_en  in  1  1 = weights may change; 0 = weights frozen
- weight  out  NUM_PRE*W_W  packed weights; channel i at [i*W_W +: W_W]
- update_w_flag  out  1  registered pulse: a weight event was applied on the previous edge
- time_diff  out  T_W  dt of the lowest-index channel updated by the latest event

Behaviour:
- One clock. Reset is synchronous and active-low: sampled only on the rising clk edge while rst_n=0.
- Reset values:
  - all timers = 2^T_W-1 ("no recent spike")
  - all armed flags = 0
  - weights = W_INIT
  - update_w_flag = 0, time_diff = 0
- A reset asserted mid-operation discards all history on that edge.
- Timers:
  - pre_t[i]: on pre_spike[i], load 0; otherwise +1, saturating at 2^T_W-1, never wrapping.
  - post_t behaves identically on post_spike.
- Armed flags:
  - pre_armed[i] is set by pre_spike[i] and cleared when channel i takes an LTP.
  - post_armed[i] is set for all i by post_spike and cleared when channel i takes an LTD.
  - Each spike therefore pairs at most once per channel.
- Effective dt, using register values before the edge:
  - LTP uses dpre = pre_spike[i] ? 0 : pre_t[i].
  - LTD uses dpost = post_t.
- Step size: delta(dt) = max(1, (WIN - dt) >> SHIFT). The arithmetic is unsigned, computed at max(T_W, W_W)+1 bits.
- LTP, on an edge with post_spike=1 and learn_en=1: for each i with (pre_armed[i] or pre_spike[i]) and dpre < WIN, w[i] = min(w[i] + delta, 2^W_W-1).
- LTD, on an edge with pre_spike[i]=1, post_spike=0 and learn_en=1: if post_armed[i] and post_t < WIN, w[i] = max(w[i] - delta, 0).
- Simultaneous pre_spike[i] and post_spike: treated as LTP with dt=0 only, never LTD. pre_armed[i] ends cleared and post_armed[i] ends set.
- Channels update in parallel on the same edge. LTP and LTD on different channels in one cycle are both applied.
- Latency: the new weight is visible one cycle after the spike is sampled. update_w_flag and time_diff update on that same edge.
- update_w_flag is 1 for exactly one cycle per edge on which any channel qualified, including qualifying events clamped by saturation. Otherwise it is 0.
- time_diff holds its value when no event occurs.
- learn_en=0: timers and armed flags still update, weights hold, update_w_flag=0, and armed flags are not consumed.

Decomposition:
- Package stdp_pkg holds:
  - default parameter constants
  - the delta function
  - the saturating add/sub functions, parametrised by width
- Sub-module stdp_spike_timer: saturating timer plus armed flag. Instantiate it NUM_PRE+1 times, with the post instance carrying a NUM_PRE-wide armed vector.

Test Plan (defaults: NUM_PRE=4, T_W=4, W_W=4, WIN=8, SHIFT=1, W_INIT=8):
1. Reset, then post_spike alone -> weight=0x8888, update_w_flag stays 0, time_diff=0 (timers saturated and unarmed).
2. pre_spike[0] at edge k, post_spike at edge k+3 -> dt=2, delta=3, w0=11, weight=0x888B, one-cycle flag, time_diff=2. A second post at k+4 leaves w0 unchanged (disarmed).
3. post_spike at edge k, pre_spike[1] at edge k+1 -> dt=0, delta=4, w1=4, weight=0x8848, flag pulse. A repeat pre[1] at k+2 gives no change.
4. Repeated simultaneous pre[2]+post (dt=0, delta=4) -> w2 goes 12, 15, 15, with the flag pulsing each time. Repeated LTD on channel 3 gives 4, 0, 0.
5. pre[0] then post 10 edges later -> dt=9 ≥ WIN, no change, no flag. Idle 40 cycles -> all timers read 15 (no wrap), and a following post gives no learning.
6. Valid pairing with learn_en=0 -> weights unchanged, flag 0. Assert rst_n=0 mid-sequence -> weight=0x8888 on the next cycle.
